alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes a 16x16 -> 16-bit (low word) unsigned/two's-complement product.
- Drives the control bits and operands of an external shared Alu16 with shift-and-add steps.
- Holds the accumulator, multiplicand and multiplier registers and a bit counter.
- Sits between the CPU's instruction decode and the Alu16 instance, which it owns while busy.

Parameters:
- NBITS, 16, number of multiplier bits processed per operation; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; accepted only in IDLE
- a  input  16  multiplicand, sampled on accept
- b  input  16  multiplier, sampled on accept
- busy  output  1  high in ADD/DBL/DONE
- done  output  1  one-cycle pulse, high in DONE
- product  output  16  result register; held until next accept
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  Alu16 control bits
- alu_x, alu_y  output  16 each  Alu16 operands
- alu_out  input  16  Alu16 result, combinational, same cycle
- alu_zr, alu_ng  input  1 each  Alu16 flags; unused except by optional feature

Behaviour:
- One clock; reset is synchronous and active-high.
- Ports are named clk and reset.
- Reset values:
  - state=IDLE; busy=0, done=0, product=0.
  - acc, mcand, mplier and cnt all 0.
  - All alu_* outputs 0.
- Reset mid-operation aborts immediately to the reset values. No partial product is retained.
- States: IDLE, ADD, DBL, DONE.
- IDLE:
  - alu_* outputs are all 0.
  - On start=1: mcand<=a, mplier<=b, acc<=0, cnt<=0, go to ADD.
- ADD:
  - Drives x+y: zx=0, nx=0, zy=0, ny=0, f=1, no=0; alu_x=acc, alu_y=mcand.
  - If mplier[0]=1: acc<=alu_out. Otherwise acc is unchanged; the ALU is still driven.
  - Go to DBL.
- DBL:
  - Drives the same x+y controls; alu_x=mcand, alu_y=mcand.
  - mcand<=alu_out, i.e. mcand<<1 mod 2^16.
  - mplier<=mplier>>1 (logical shift), cnt<=cnt+1.
  - If cnt==NBITS-1: go to DONE. Otherwise go to ADD.
- DONE:
  - product<=acc, done=1, alu_* outputs 0.
  - Go to IDLE next cycle.
- Latency: start accepted at edge k -> DONE occupies cycle k+1+2*NBITS (k+33 for the default).
  - product is valid from the edge ending DONE.
  - done is high during DONE.
- Arithmetic is modulo 2^16. Overflow is silently discarded; the result equals the low 16 bits of a*b for signed or unsigned operands.
- start while busy=1 is ignored, with no queuing.
- start in the DONE cycle is ignored; the requester re-asserts it in IDLE.
- start held continuously produces back-to-back operations separated by one IDLE cycle.
- alu_* outputs are purely a function of state and registers. There is no combinational path from start to alu_*.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined:
  - In DBL, if the shifted multiplier (mplier>>1) is 0, go to DONE regardless of cnt.
  - DONE also latches a registered zero flag prod_zr=(acc==0), exposed as an extra 1-bit output prod_zr; it resets to 0.
  - Latency becomes 1+2*(index of highest set bit of b, plus 1) cycles, minimum 3.
  - b=0 exits after the first ADD/DBL pair.
- Undefined: fixed latency as above, no prod_zr port.

Test Plan:
- reset, then start with a=3, b=5 -> busy rises next cycle; done pulses exactly 33 cycles after accept; product=15 (0x000F).
- a=0xFFFF, b=0xFFFF -> product=0x0001; a=0x8000, b=2 -> product=0x0000 (wrap).
- During the first ADD, check alu_zx..alu_no = 0,0,0,0,1,0 with alu_x=acc, alu_y=mcand -> matches spec. In IDLE, all alu_* outputs = 0.
- start pulsed again at cycle 10 of an operation with a=7, b=7 -> ignored; first result (a=2, b=9 -> 18) unaffected; done fires once.
- reset asserted at cycle 12 of a=100, b=200 -> next cycle state is IDLE, busy=0, product=0. A fresh start with a=6, b=7 yields 42.
- With ALU_MUL_EARLY_EXIT_EN: a=9, b=1 -> done at accept+3, product=9, prod_zr=0; a=9, b=0 -> done at accept+3, product=0, prod_zr=1.

Source files
------------

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Shift-and-add 16x16 -> 16-bit (low word) multiply sequencer
//               that drives a shared external Alu16. Optional build macro
//               ALU_MUL_EARLY_EXIT_EN adds early exit and a prod_zr flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int NBITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
`ifdef ALU_MUL_EARLY_EXIT_EN
    output logic        prod_zr,
`endif
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DBL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_CNT = 5'(NBITS - 1);

    state_t      r_state;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_product;
    logic        w_last;

    // ALU flags are only meaningful to callers that inspect them directly.
    logic        w_unused_flags;
    assign w_unused_flags = alu_zr ^ alu_ng;

`ifdef ALU_MUL_EARLY_EXIT_EN
    logic        r_prod_zr;
    assign w_last  = (r_cnt == C_LAST_CNT) || ((r_mplier >> 1) == 16'd0);
    assign prod_zr = r_prod_zr;
`else
    assign w_last  = (r_cnt == C_LAST_CNT);
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= 16'd0;
            r_mcand   <= 16'd0;
            r_mplier  <= 16'd0;
            r_cnt     <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= 16'd0;
`ifdef ALU_MUL_EARLY_EXIT_EN
            r_prod_zr <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= 16'd0;
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (r_mplier[0]) begin
                        r_acc <= alu_out;
                    end
                    r_state <= S_DBL;
                end
                S_DBL: begin
                    // alu_out here is mcand+mcand, i.e. the doubled multiplicand
                    r_mcand  <= alu_out;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_ADD;
                    end
                end
                S_DONE: begin
                    r_product <= r_acc;
`ifdef ALU_MUL_EARLY_EXIT_EN
                    r_prod_zr <= (r_acc == 16'd0);
`endif
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU drive is decoded from state and registers only, never from start.
    always_comb begin
        alu_zx = 1'b0;
        alu_nx = 1'b0;
        alu_zy = 1'b0;
        alu_ny = 1'b0;
        alu_f  = 1'b0;
        alu_no = 1'b0;
        alu_x  = 16'd0;
        alu_y  = 16'd0;
        case (r_state)
            S_ADD: begin
                alu_f = 1'b1;
                alu_x = r_acc;
                alu_y = r_mcand;
            end
            S_DBL: begin
                alu_f = 1'b1;
                alu_x = r_mcand;
                alu_y = r_mcand;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_seq
// Description : Directed self-checking bench for alu_mul_seq with an Alu16
//               behavioural model closing the ALU loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
`ifdef ALU_MUL_EARLY_EXIT_EN
    logic        prod_zr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mul_seq #(.NBITS(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
`ifdef ALU_MUL_EARLY_EXIT_EN
        .prod_zr (prod_zr),
`endif
        .alu_zx  (alu_zx),
        .alu_nx  (alu_nx),
        .alu_zy  (alu_zy),
        .alu_ny  (alu_ny),
        .alu_f   (alu_f),
        .alu_no  (alu_no),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_out (alu_out),
        .alu_zr  (alu_zr),
        .alu_ng  (alu_ng)
    );

    // Hack-style Alu16 model
    always_comb begin
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        x = alu_zx ? 16'd0 : alu_x;
        x = alu_nx ? ~x : x;
        y = alu_zy ? 16'd0 : alu_y;
        y = alu_ny ? ~y : y;
        o = alu_f ? (x + y) : (x & y);
        o = alu_no ? ~o : o;
        alu_out = o;
        alu_zr  = (o == 16'd0);
        alu_ng  = o[15];
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] alu_vec();
        return {2'b00, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y};
    endfunction

    // Cycles from the accepting edge to the DONE cycle
    function automatic int lat(input logic [15:0] mb);
`ifdef ALU_MUL_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 16; i++) if (mb[i]) h = i;
        return 1 + 2 * (h + 1);
`else
        return 33;
`endif
    endfunction

    task automatic mul(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] exp,
                       input int pulse_at);
        int n;
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        check("busy_rise", {39'd0, busy}, 40'd1);
        check("first_add_alu", alu_vec(), {2'b00, 6'b000010, 16'd0, ta});
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (n == pulse_at) begin
                a = 16'd7; b = 16'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 40'(n), 40'(lat(tb)));
        check("done_high", {39'd0, done}, 40'd1);
        @(negedge clk);
        check("done_pulse_end", {39'd0, done}, 40'd0);
        check("busy_fall", {39'd0, busy}, 40'd0);
        check("product", {24'd0, product}, {24'd0, exp});
        check("idle_alu_zero", alu_vec(), 40'd0);
`ifdef ALU_MUL_EARLY_EXIT_EN
        check("prod_zr", {39'd0, prod_zr}, {39'd0, (exp == 16'd0)});
`endif
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {39'd0, busy}, 40'd0);
        check("rst_done", {39'd0, done}, 40'd0);
        check("rst_product", {24'd0, product}, 40'd0);
        check("rst_alu", alu_vec(), 40'd0);
        reset = 1'b0;

        mul(16'd3, 16'd5, 16'h000F, 0);
        mul(16'hFFFF, 16'hFFFF, 16'h0001, 0);
        mul(16'h8000, 16'd2, 16'h0000, 0);
        mul(16'h1234, 16'd3, 16'h369C, 0);

        // start pulsed mid-operation must be ignored
        mul(16'd2, 16'd9, 16'd18, 10);
        @(negedge clk);
        check("no_restart", {39'd0, busy}, 40'd0);
        check("no_second_done", {39'd0, done}, 40'd0);

        // reset mid-operation aborts and clears the product
        @(negedge clk);
        a = 16'd100; b = 16'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 12; i++) @(negedge clk);
        check("busy_before_rst", {39'd0, busy}, 40'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {39'd0, busy}, 40'd0);
        check("abort_done", {39'd0, done}, 40'd0);
        check("abort_product", {24'd0, product}, 40'd0);
        check("abort_alu", alu_vec(), 40'd0);
        mul(16'd6, 16'd7, 16'd42, 0);

        // start held high: one IDLE cycle between operations
        @(negedge clk);
        a = 16'd5; b = 16'd5; start = 1'b1;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency", 40'(n), 40'(lat(16'd5)));
        @(negedge clk);
        check("b2b_idle_gap", {39'd0, busy}, 40'd0);
        check("b2b_product", {24'd0, product}, 40'd25);
        @(negedge clk);
        start = 1'b0;
        check("b2b_restart", {39'd0, busy}, 40'd1);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency2", 40'(n), 40'(lat(16'd5)));
        @(negedge clk);
        check("b2b_product2", {24'd0, product}, 40'd25);

`ifdef ALU_MUL_EARLY_EXIT_EN
        mul(16'd9, 16'd1, 16'd9, 0);
        mul(16'd9, 16'd0, 16'd0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
